// File: rtl/ksa_serial_ctrl.sv
// Byte-serial sequencer around a combinational 8-bit Kogge-Stone adder.
// Accepts one W-bit add request, feeds the adder LSB byte first and returns sum and carry-out.
module ksa_serial_ctrl #(
    parameter int unsigned NBYTES = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [8*NBYTES-1:0] i_a,
    input  logic [8*NBYTES-1:0] i_b,
    input  logic                i_cin,
    output logic                o_ksa_c0,
    output logic [7:0]          o_ksa_a,
    output logic [7:0]          o_ksa_b,
    input  logic [7:0]          i_ksa_s,
    input  logic                i_ksa_carry,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [8*NBYTES-1:0] o_sum,
    output logic                o_cout
);

    localparam int unsigned W  = 8 * NBYTES;
    localparam int unsigned IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] idx, idx_nxt;
    logic [W-1:0]  a_sh, a_sh_nxt;
    logic [W-1:0]  b_sh, b_sh_nxt;
    logic [W-1:0]  sum_reg, sum_nxt;
    logic          carry_reg, carry_nxt;
    logic          cout_nxt, ready_nxt, valid_nxt, c0_nxt;
    logic [7:0]    ksa_a_nxt, ksa_b_nxt;

    assign o_sum = sum_reg;

    // State and datapath registers; adder drive and handshakes are registered from next state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            idx       <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            o_cout    <= 1'b0;
            o_ready   <= 1'b1;
            o_valid   <= 1'b0;
            o_ksa_a   <= '0;
            o_ksa_b   <= '0;
            o_ksa_c0  <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            a_sh      <= a_sh_nxt;
            b_sh      <= b_sh_nxt;
            sum_reg   <= sum_nxt;
            carry_reg <= carry_nxt;
            o_cout    <= cout_nxt;
            o_ready   <= ready_nxt;
            o_valid   <= valid_nxt;
            o_ksa_a   <= ksa_a_nxt;
            o_ksa_b   <= ksa_b_nxt;
            o_ksa_c0  <= c0_nxt;
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        a_sh_nxt  = a_sh;
        b_sh_nxt  = b_sh;
        sum_nxt   = sum_reg;
        carry_nxt = carry_reg;
        cout_nxt  = o_cout;

        case (state)
            IDLE: begin
                if (i_valid) begin
                    a_sh_nxt  = i_a;
                    b_sh_nxt  = i_b;
                    carry_nxt = i_cin;
                    sum_nxt   = '0;
                    idx_nxt   = '0;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                for (int k = 0; k < int'(NBYTES); k++) begin
                    if (idx == IW'(k)) sum_nxt[8*k +: 8] = i_ksa_s;
                end
                carry_nxt = i_ksa_carry;
                a_sh_nxt  = a_sh >> 8;
                b_sh_nxt  = b_sh >> 8;
                if (idx == LAST) begin
                    cout_nxt  = i_ksa_carry;
                    state_nxt = DONE;
                end else begin
                    idx_nxt = idx + IW'(1);
                end
            end
            DONE: begin
                if (i_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        ready_nxt = (state_nxt == IDLE);
        valid_nxt = (state_nxt == DONE);
        // Adder sees the low byte of the shifters and the chained carry only while running.
        ksa_a_nxt = (state_nxt == RUN) ? a_sh_nxt[7:0] : 8'h00;
        ksa_b_nxt = (state_nxt == RUN) ? b_sh_nxt[7:0] : 8'h00;
        c0_nxt    = (state_nxt == RUN) ? carry_nxt : 1'b0;
    end

endmodule

// File: tb/tb_ksa_serial_ctrl.sv
// Scoreboard bench for ksa_serial_ctrl with a behavioural 8-bit adder attached.
// Expected results come from whole-word arithmetic; a monitor checks each result as it appears.
module tb_ksa_serial_ctrl;

    localparam int unsigned NB = 4;
    localparam int unsigned W  = 8 * NB;

    typedef struct {
        logic [W:0] res;
        int         acc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         valid_in, ready_out, cin;
    logic [W-1:0] a, b;
    logic         ksa_c0, ksa_carry;
    logic [7:0]   ksa_a, ksa_b, ksa_s;
    logic         valid_out, ready_in;
    logic [W-1:0] sum;
    logic         cout;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    logic prev_valid = 1'b0;
    exp_t exp_q[$];

    ksa_serial_ctrl #(.NBYTES(NB)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_valid(valid_in), .o_ready(ready_out),
        .i_a(a), .i_b(b), .i_cin(cin),
        .o_ksa_c0(ksa_c0), .o_ksa_a(ksa_a), .o_ksa_b(ksa_b),
        .i_ksa_s(ksa_s), .i_ksa_carry(ksa_carry),
        .o_valid(valid_out), .i_ready(ready_in),
        .o_sum(sum), .o_cout(cout)
    );

    // Behavioural stand-in for the combinational Kogge-Stone adder.
    assign {ksa_carry, ksa_s} = 9'(ksa_a) + 9'(ksa_b) + 9'(ksa_c0);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare each new result against the oldest outstanding request.
    always @(negedge clk) begin
        if (valid_out && !prev_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", 64'(valid_out), 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result", 64'({cout, sum}), 64'(e.res));
                check("latency", 64'(cyc - e.acc), 64'(NB + 1));
            end
        end
        prev_valid = valid_out;
    end

    // Carry into byte i of a+b+c, from whole-word arithmetic on the low i bytes.
    function automatic logic carry_into(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic c, input int i);
        logic [W:0] m, p;
        m = ((W+1)'(1) << (8 * i)) - (W+1)'(1);
        p = ((W+1)'(x) & m) + ((W+1)'(y) & m) + (W+1)'(c);
        return p[8*i];
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!ready_out && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready_out) check("ready_timeout", 64'(ready_out), 64'd1);
    endtask

    task automatic run_txn(input logic [W-1:0] ta, input logic [W-1:0] tb,
                           input logic tc, input int stall);
        exp_t       e;
        logic [W:0] held;
        wait_ready();
        a = ta; b = tb; cin = tc; valid_in = 1'b1; ready_in = (stall == 0);
        e.res = (W+1)'(ta) + (W+1)'(tb) + (W+1)'(tc);
        e.acc = cyc;
        exp_q.push_back(e);
        for (int i = 0; i < int'(NB); i++) begin
            @(negedge clk);
            if (i == 0) begin
                valid_in = 1'b1;
                a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            end
            check("run_ksa_a", 64'(ksa_a), 64'(ta[8*i +: 8]));
            check("run_ksa_b", 64'(ksa_b), 64'(tb[8*i +: 8]));
            check("run_ksa_c0", 64'(ksa_c0), 64'(carry_into(ta, tb, tc, i)));
            check("run_ready", 64'(ready_out), 64'd0);
        end
        valid_in = 1'b0;
        @(negedge clk);
        check("done_valid", 64'(valid_out), 64'd1);
        held = {cout, sum};
        repeat (stall) begin
            valid_in = 1'($urandom);
            @(negedge clk);
            check("stall_valid", 64'(valid_out), 64'd1);
            check("stall_ready", 64'(ready_out), 64'd0);
            check("stall_hold", 64'({cout, sum}), 64'(held));
            check("stall_ksa_a", 64'(ksa_a), 64'd0);
        end
        valid_in = 1'b0;
        ready_in = 1'b1;
        @(negedge clk);
        check("post_valid", 64'(valid_out), 64'd0);
        check("post_ready", 64'(ready_out), 64'd1);
    endtask

    initial begin
        rst = 1'b1; valid_in = 1'b0; ready_in = 1'b1; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_ready", 64'(ready_out), 64'd1);
        check("rst_valid", 64'(valid_out), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_cout", 64'(cout), 64'd0);
        check("rst_ksa", 64'({ksa_c0, ksa_a, ksa_b}), 64'd0);

        run_txn(32'h0000_0001, 32'h0000_0002, 1'b0, 0);
        run_txn(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
        run_txn(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 0);
        run_txn(32'hA5A5_5A5A, 32'h0F0F_F0F0, 1'b1, 3);

        // Reset in the second RUN cycle discards the in-flight add.
        wait_ready();
        a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; cin = 1'b1; valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_ready", 64'(ready_out), 64'd1);
        check("midrst_valid", 64'(valid_out), 64'd0);
        check("midrst_sum", 64'({cout, sum}), 64'd0);
        check("midrst_ksa", 64'({ksa_c0, ksa_a, ksa_b}), 64'd0);
        repeat (6) @(negedge clk);
        check("midrst_no_valid", 64'(valid_out), 64'd0);
        run_txn(32'h8000_0000, 32'h8000_0000, 1'b0, 0);

        for (int t = 0; t < 25; t++) begin
            run_txn(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
        end
        run_txn(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1);
        run_txn(32'h0000_0000, 32'h0000_0000, 1'b0, 0);

        repeat (3) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ksa_serial_ctrl.md
Name: ksa_serial_ctrl

Overview:
- Byte-serial sequencer that adds two 8*NBYTES-bit operands with the existing combinational 8-bit Kogge-Stone adder.
- Sits directly in front of and behind the adder. It drives the adder's c0/i_a/i_b inputs one byte per cycle and consumes o_s/o_carry, chaining the carry through a register.
- Presents a valid/ready request interface upstream and a valid/ready result interface downstream.

Parameters:
NBYTES, 4, operand width in bytes (legal range >= 1); operand width W = 8*NBYTES

Ports:
i_clk  input  1  clock; all state updates on rising edge
i_rst  input  1  synchronous, active-high reset
i_valid  input  1  request valid
o_ready  output  1  request ready; high only in IDLE
i_a  input  W  operand A
i_b  input  W  operand B
i_cin  input  1  carry-in for the least-significant byte
o_ksa_c0  output  1  to adder c0
o_ksa_a  output  8  to adder i_a
o_ksa_b  output  8  to adder i_b
i_ksa_s  input  8  from adder o_s
i_ksa_carry  input  1  from adder o_carry
o_valid  output  1  result valid
i_ready  input  1  result accepted by downstream
o_sum  output  W  result sum
o_cout  output  1  carry-out of the most-significant byte

Behaviour:
- Clock and reset: one clock, i_clk. i_rst is synchronous and active-high.
- Reset effects:
  - FSM goes to IDLE; byte index goes to 0.
  - Operand shift registers, sum register and carry register are cleared to 0.
  - Outputs after reset: o_valid=0, o_ready=1, o_sum=0, o_cout=0, o_ksa_a=0, o_ksa_b=0, o_ksa_c0=0.
  - Reset takes effect from any state, including mid-RUN. The in-flight operation is discarded and no o_valid is produced for it.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - o_ready=1.
  - On i_valid && o_ready: latch i_a and i_b into shift registers, set carry_reg=i_cin, clear sum_reg, set idx=0, go to RUN.
  - i_a, i_b and i_cin are don't-care after the acceptance edge.
- RUN:
  - o_ready=0.
  - Adder drive:
    - o_ksa_a = a_sh[7:0]
    - o_ksa_b = b_sh[7:0]
    - o_ksa_c0 = carry_reg
  - Each edge:
    - sum_reg byte idx <= i_ksa_s
    - carry_reg <= i_ksa_carry
    - a_sh and b_sh shift right by 8 with zero fill
    - idx <= idx+1
  - On the edge where idx == NBYTES-1: go to DONE, o_cout <= i_ksa_carry.
  - i_valid is ignored throughout RUN.
- DONE:
  - o_valid=1, o_ready=0.
  - o_sum and o_cout are held stable.
  - On i_ready: go to IDLE, o_valid=0 next cycle.
  - While i_ready=0: hold indefinitely; i_valid is ignored.
- Adder drive outside RUN: o_ksa_a, o_ksa_b and o_ksa_c0 are driven 0 in IDLE and DONE.
- Latency:
  - Acceptance edge = cycle 0.
  - RUN occupies cycles 1..NBYTES.
  - o_valid is first high in cycle NBYTES+1.
  - For NBYTES=1, RUN lasts exactly one cycle.
- Throughput: one transaction per NBYTES+2 cycles minimum, because there is no overlap. DONE -> IDLE costs one cycle before the next acceptance.
- Carry and width rules:
  - The carry chain is strictly byte-ordered, LSB first.
  - o_sum is the sum modulo 2^W; o_cout is bit W of A+B+cin.
  - No signed interpretation.
- Adder assumption: the attached adder is purely combinational, so its outputs are valid within the same cycle they are driven.
- Counter width: idx is clog2(NBYTES) bits, minimum 1. It never wraps past NBYTES-1.
- Simultaneous events:
  - i_valid asserted in DONE together with i_ready: only the result handshake completes; the request is accepted in the following IDLE cycle if i_valid is still high.
  - i_rst together with any handshake: reset wins.

Test Plan:
(NBYTES=4, bench instantiates the 8-bit KSA between the o_ksa_* and i_ksa_* ports)
1. Hold i_rst=1 for 2 cycles, then release -> o_ready=1, o_valid=0, o_sum=0x00000000, o_cout=0, o_ksa_a=o_ksa_b=0.
2. A=0x00000001, B=0x00000002, cin=0, accepted at cycle 0 -> o_valid first high at cycle 5, o_sum=0x00000003, o_cout=0.
3. A=0xFFFFFFFF, B=0x00000001, cin=0 -> o_ksa_c0 = 0,1,1,1 across RUN cycles 1-4; o_sum=0x00000000, o_cout=1.
4. A=0x12345678, B=0x9ABCDEF0, cin=1 -> o_sum=0xACF13569, o_cout=0; o_ksa_a sequence 0x78,0x56,0x34,0x12.
5. Result backpressure: hold i_ready=0 for 3 cycles in DONE while toggling i_valid -> o_valid and o_sum remain stable, o_ready=0, no new acceptance. Then i_ready=1 -> o_valid=0 and o_ready=1 next cycle.
6. Reset in RUN cycle 2 of A=0xFFFFFFFF, B=0xFFFFFFFF -> next cycle IDLE, o_valid never asserted, sum cleared. Follow-up A=0x80000000, B=0x80000000, cin=0 -> o_sum=0x00000000, o_cout=1.
